// File: rtl/ref_window_fetch.sv
// Fetches the 15 integer-pixel rows of a reference window from row memory,
// assembles them into one wide buffer and holds it under valid/ready.
module ref_window_fetch #(
  parameter int NUM_PIXEL = 8,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 16,
  parameter int MAX_OUT   = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [ADDR_W-1:0]                              base_addr,
  input  logic [ADDR_W-1:0]                              stride,
  output logic                                           busy,
  output logic                                           mem_rd_en,
  output logic [ADDR_W-1:0]                              mem_addr,
  input  logic                                           mem_rd_valid,
  input  logic [(NUM_PIXEL+7)*PIX_W-1:0]                 mem_rd_data,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [(NUM_PIXEL+7)*(NUM_PIXEL+7)*PIX_W-1:0]   out_buffer,
  output logic                                           err
);

  localparam int WIN   = NUM_PIXEL + 7;
  localparam int ROW_W = WIN * PIX_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(WIN);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   req_cnt;
  logic [CNT_W-1:0]   rcv_cnt;
  logic [CNT_W-1:0]   rcv_nxt;
  logic [CNT_W-1:0]   in_flight;
  logic [ADDR_W-1:0]  next_addr;
  logic [ADDR_W-1:0]  stride_q;
  logic               rtn_ok;
  logic               drop_err;
  logic               issue;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A return is accepted only while something is outstanding in FETCH; the
  // throttle sees this cycle's return already retired.
  always_comb begin
    rtn_ok   = 1'b0;
    drop_err = 1'b0;
    if (mem_rd_valid) begin
      if (state == FETCH) begin
        if (rcv_cnt != req_cnt) rtn_ok   = 1'b1;
        else                    drop_err = 1'b1;
      end else if (state == HOLD) begin
        drop_err = 1'b1;
      end
    end
    rcv_nxt   = rcv_cnt + {{(CNT_W-1){1'b0}}, rtn_ok};
    in_flight = req_cnt - rcv_nxt;
    issue     = (state == FETCH) && (req_cnt < LAST_ROW) && (in_flight < MAX_OUT_C);

    state_nxt = state;
    case (state)
      IDLE:    if (start)                state_nxt = FETCH;
      FETCH:   if (rcv_nxt == LAST_ROW)  state_nxt = HOLD;
      HOLD:    if (out_ready)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      req_cnt    <= '0;
      rcv_cnt    <= '0;
      err        <= 1'b0;
      out_buffer <= '0;
    end else begin
      mem_rd_en <= issue;
      if (state == IDLE && start) begin
        req_cnt <= '0;
        rcv_cnt <= '0;
        err     <= 1'b0;
      end
      if (issue) begin
        mem_addr <= next_addr;
        req_cnt  <= req_cnt + 1'b1;
      end
      if (rtn_ok) begin
        rcv_cnt <= rcv_nxt;
        for (int r = 0; r < WIN; r++) begin
          if (rcv_cnt == CNT_W'(r)) out_buffer[r*ROW_W +: ROW_W] <= mem_rd_data;
        end
      end
      if (drop_err) err <= 1'b1;
    end
  end

  // Address generator; wraps modulo 2^ADDR_W by construction.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      next_addr <= base_addr;
      stride_q  <= stride;
    end else if (issue) begin
      next_addr <= next_addr + stride_q;
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_ref_window_fetch.sv
// Scoreboard bench for ref_window_fetch: behavioural memory, expected address
// and window queues, and a monitor that checks every request and transfer.
module tb_ref_window_fetch;

  localparam int MAXO  = 4;
  localparam int WIN   = 15;
  localparam int ROW_W = 120;
  localparam int BUF_W = WIN * ROW_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       base_addr;
  logic [15:0]       stride;
  logic              busy;
  logic              mem_rd_en;
  logic [15:0]       mem_addr;
  logic              mem_rd_valid;
  logic [ROW_W-1:0]  mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [BUF_W-1:0]  out_buffer;
  logic              err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0]      addr_q[$];
  logic [BUF_W-1:0] win_q[$];

  int               rq_due[$];
  logic [ROW_W-1:0] rq_dat[$];
  int               mem_lat  = 1;
  int               ret_cnt  = 0;
  int               cyc      = 0;
  bit               inject   = 1'b0;
  bit               chk_out  = 1'b0;
  bit               pat_mode = 1'b0;
  logic [15:0]      pbase    = '0;
  logic [15:0]      pstride  = 16'd1;

  ref_window_fetch #(.NUM_PIXEL(8), .PIX_W(8), .ADDR_W(16), .MAX_OUT(MAXO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_buffer(out_buffer), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_win(input string nm, input logic [BUF_W-1:0] act, input logic [BUF_W-1:0] exp);
    int bad;
    bad = -1;
    n_chk++;
    for (int r = WIN-1; r >= 0; r--)
      if (act[r*ROW_W +: ROW_W] !== exp[r*ROW_W +: ROW_W]) bad = r;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: row %0d got %h expected %h", nm, bad,
               act[bad*ROW_W +: ROW_W], exp[bad*ROW_W +: ROW_W]);
    end
  endtask

  // Memory contents: either the r*16+c test pattern or an address hash.
  function automatic logic [ROW_W-1:0] row_of(input logic [15:0] a);
    logic [ROW_W-1:0] v;
    logic [15:0]      r;
    r = pat_mode ? (a - pbase) / pstride : 16'd0;
    for (int c = 0; c < WIN; c++)
      v[c*8 +: 8] = pat_mode ? 8'(r*16 + c) : 8'(a[7:0]*7 + a[15:8] + c*29 + 8'h5a);
    return v;
  endfunction

  // In-order memory with fixed latency per fetch.
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_rd_en) begin
        rq_due.push_back(cyc + mem_lat);
        rq_dat.push_back(row_of(mem_addr));
        if (chk_out) chk("outstanding_le_max", 64'(rq_due.size() <= MAXO), 64'd1);
      end
      if (inject) begin
        inject       = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = {$urandom, $urandom, $urandom, $urandom};
      end else if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        void'(rq_due.pop_front());
        mem_rd_valid = 1'b1;
        mem_rd_data  = rq_dat.pop_front();
        ret_cnt++;
      end else begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
      end
    end
  end

  // Monitor: every request address and every accepted window against the queues.
  initial begin
    logic [15:0]      ea;
    logic [BUF_W-1:0] ew;
    forever begin
      @(negedge clk);
      #1;
      if (mem_rd_en) begin
        if (addr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mem_addr: request at %h, none expected", mem_addr);
        end else begin
          ea = addr_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(ea));
        end
      end
      if (out_valid && out_ready) begin
        if (win_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL window: transfer with no window expected");
        end else begin
          ew = win_q.pop_front();
          cmp_win("window", out_buffer, ew);
        end
      end
    end
  end

  task automatic do_fetch(input logic [15:0] b, input logic [15:0] s, input int lat);
    logic [BUF_W-1:0] w;
    logic [15:0]      a;
    mem_lat = lat;
    for (int r = 0; r < WIN; r++) begin
      a = b + 16'(r) * s;
      addr_q.push_back(a);
      w[r*ROW_W +: ROW_W] = row_of(a);
    end
    win_q.push_back(w);
    @(negedge clk);
    start = 1'b1; base_addr = b; stride = s;
    @(negedge clk);
    start = 1'b0; base_addr = 16'($urandom); stride = 16'($urandom);
  endtask

  task automatic wait_valid(input int lim);
    int k;
    k = 0;
    while (!out_valid && k < lim) begin @(negedge clk); k++; end
    if (!out_valid) begin
      n_chk++; n_fail++;
      $display("FAIL wait_valid: out_valid=0 after %0d cycles, required 1", lim);
    end
  endtask

  task automatic wait_done(input bit rnd, input int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      k++;
    end
    if (busy) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: busy=1 after %0d cycles, required 0", lim);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, first, last, nreq;
    logic [BUF_W-1:0] wsave;
    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_en", 64'(mem_rd_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_buf_zero", 64'(out_buffer == '0), 64'd1);
    chk("rst_err", 64'(err), 64'd0);

    // Basic fetch with cycle-accurate latency
    pat_mode = 1'b1; pbase = 16'h0100; pstride = 16'h0040;
    do_fetch(16'h0100, 16'h0040, 1);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk($sformatf("basic_en_c%0d", k), 64'(mem_rd_en), 64'(k <= 15));
      chk($sformatf("basic_valid_c%0d", k), 64'(out_valid), 64'(k == 17));
    end
    wait_done(1'b0, 20);
    pat_mode = 1'b0;

    // Backpressure, with start pulses in HOLD and on the transfer cycle
    out_ready = 1'b0;
    do_fetch(16'h0500, 16'h0077, 1);
    wait_valid(300);
    wsave = (win_q.size() > 0) ? win_q[0] : '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i % 6 == 2);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_en", 64'(mem_rd_en), 64'd0);
      cmp_win("bp_stable", out_buffer, wsave);
    end
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bp_idle_busy", 64'(busy), 64'd0);
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    cmp_win("bp_buf_kept", out_buffer, wsave);
    @(negedge clk);
    chk("bp_start_ignored", 64'(busy), 64'd0);

    // Throttling with long memory latency
    r0 = ret_cnt; first = -1; last = 0; nreq = 0;
    chk_out = 1'b1;
    do_fetch(16'h2000, 16'h0120, 6);
    for (int k = 0; k < 400 && !out_valid; k++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        if (first < 0) first = k;
        last = k; nreq++;
      end
    end
    chk("thr_valid", 64'(out_valid), 64'd1);
    chk("thr_nreq", 64'(nreq), 64'd15);
    chk("thr_gaps", 64'((last - first + 1 - nreq) > 0), 64'd1);
    chk("thr_returns", 64'(ret_cnt - r0), 64'd15);
    wait_done(1'b0, 20);
    chk_out = 1'b0;

    // Address wrap
    do_fetch(16'hFFF0, 16'h0008, 2);
    wait_done(1'b0, 300);
    chk("wrap_err", 64'(err), 64'd0);

    // Reset mid-fetch, late returns in IDLE, then refetch
    r0 = ret_cnt;
    do_fetch(16'h3000, 16'h0010, 3);
    for (int k = 0; k < 200 && (ret_cnt - r0) < 7; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    addr_q.delete(); win_q.delete();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_en", 64'(mem_rd_en), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_buf_zero", 64'(out_buffer == '0), 64'd1);
    chk("mid_rst_err", 64'(err), 64'd0);
    repeat (15) @(negedge clk);
    chk("late_ret_err", 64'(err), 64'd0);
    chk("late_ret_drained", 64'(rq_due.size()), 64'd0);
    do_fetch(16'h3000, 16'h0010, 2);
    wait_done(1'b0, 300);

    // Protocol error in HOLD
    out_ready = 1'b0;
    do_fetch(16'h4000, 16'h0100, 2);
    wait_valid(300);
    wsave = (win_q.size() > 0) ? win_q[0] : '0;
    inject = 1'b1;
    repeat (3) @(negedge clk);
    chk("perr_err", 64'(err), 64'd1);
    chk("perr_valid", 64'(out_valid), 64'd1);
    cmp_win("perr_window", out_buffer, wsave);
    wait_done(1'b0, 20);
    chk("perr_sticky", 64'(err), 64'd1);
    do_fetch(16'h4800, 16'h0030, 1);
    chk("perr_cleared", 64'(err), 64'd0);
    wait_done(1'b0, 300);

    // Randomised fetches with random consumer backpressure
    for (int t = 0; t < 6; t++) begin
      do_fetch(16'($urandom), 16'($urandom), $urandom_range(1, 8));
      wait_done(1'b1, 800);
      chk("rand_err", 64'(err), 64'd0);
    end

    repeat (3) @(negedge clk);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    chk("win_q_empty", 64'(win_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ref_window_fetch.md
Name: ref_window_fetch

Overview:
Upstream feeder for the subpixel interpolation stage. On a start pulse it reads the 15 integer-pixel rows of a reference block from row-organised reference memory (NUM_PIXEL+7 rows of NUM_PIXEL+7 pixels, 8 bits each). It assembles them into the 1800-bit window consumed as in_buffer, then holds the window under a valid/ready handshake until the interpolator takes it. It tracks outstanding reads and bounds how many are in flight.

Parameters:
NUM_PIXEL, 8, block edge in pixels; window edge WIN = NUM_PIXEL+7 = 15
PIX_W, 8, bits per pixel; row width ROW_W = WIN*PIX_W = 120
ADDR_W, 16, reference memory row-address width
MAX_OUT, 4, maximum outstanding row reads (1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin fetch; sampled only in IDLE
base_addr  in  ADDR_W  row address of window row 0; captured with start
stride  in  ADDR_W  address step between consecutive rows; captured with start
busy  out  1  high in FETCH or HOLD
mem_rd_en  out  1  row read request, registered
mem_addr  out  ADDR_W  row address, valid with mem_rd_en
mem_rd_valid  in  1  returned row valid; returns are in request order, latency ≥1 cycle
mem_rd_data  in  ROW_W  returned row, pixel c at bits [c*PIX_W +: PIX_W]
out_valid  out  1  window complete and stable
out_ready  in  1  consumer accepts window
out_buffer  out  WIN*ROW_W  window: row r at [r*ROW_W +: ROW_W]
err  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at an edge): state IDLE. busy=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_buffer=0, err=0. req_cnt=0, rcv_cnt=0. Reset mid-operation abandons all outstanding reads.
- State IDLE:
  - start=1 captures base_addr and stride, sets next_addr=base_addr, clears req_cnt, rcv_cnt and err, and moves to FETCH.
  - mem_rd_valid in IDLE, including late returns after a reset, is dropped silently.
- State FETCH:
  - Each cycle, mem_rd_en is registered high iff req_cnt<15 and (req_cnt−rcv_cnt)<MAX_OUT. The outstanding count is evaluated with the current cycle's return already counted.
  - On a request: mem_addr=next_addr; next_addr += stride (mod 2^ADDR_W, wrap permitted); req_cnt++.
  - On mem_rd_valid: out_buffer row rcv_cnt ← mem_rd_data; rcv_cnt++.
  - A request and a return in the same cycle are both processed.
  - When rcv_cnt reaches 15 the block moves to HOLD. out_valid=1 starting the next cycle.
  - mem_rd_valid when rcv_cnt==req_cnt (nothing outstanding): data is dropped and err=1.
- State HOLD:
  - out_valid=1 and out_buffer stable. No requests are issued.
  - out_valid&&out_ready: transfer; the block goes to IDLE and out_valid=0 next cycle. out_buffer keeps its contents until overwritten by the next fetch.
  - start in HOLD, including the transfer cycle, is ignored. start is honoured only in IDLE, so a new fetch begins at the earliest one cycle after transfer.
  - mem_rd_valid in HOLD: dropped, err=1.
- busy=1 in FETCH and HOLD.
- mem_rd_en is deasserted in the cycle after the 15th request and stays low.
- Latency with 1-cycle memory and MAX_OUT≥2:
  - start sampled at edge 0.
  - Requests at cycles 1..15.
  - Returns at cycles 2..16.
  - out_valid=1 from cycle 17.
- With MAX_OUT=1 the reads serialise: request, wait for return, then the next request.
- Counters are 4 bits wide; they never exceed 15.

Test Plan:
- Basic fetch: 1-cycle memory returning row r with pixel c = r*16+c; base_addr=0x0100, stride=0x0040; start pulse → mem_addr sequence 0x0100, 0x0140, … 0x0480 on cycles 1..15; out_valid at cycle 17; out_buffer[(r*120+c*8)+:8] = r*16+c for all r,c<15.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_valid stays 1, out_buffer unchanged, mem_rd_en=0, start pulses ignored; out_ready=1 → IDLE next cycle, busy=0.
- Throttling: memory latency 6 cycles, MAX_OUT=4 → the outstanding count never exceeds 4 and mem_rd_en gaps appear. Rows land in order and out_valid is asserted after the 15th return.
- Address wrap: base_addr=0xFFF0, stride=0x0008 → addresses 0xFFF0, 0xFFF8, 0x0000, … 0x0060; no err.
- Reset mid-fetch: rst asserted after 7 returns → all outputs return to reset values next cycle. Late returns in IDLE do not set err. A new start refetches the full 15 rows correctly.
- Protocol error: inject an extra mem_rd_valid in HOLD → err=1 and the window is unchanged. The next start clears err.
